// File: rtl/axi_bresp_queue.sv
// AXI B-channel response queue: buffers {bid,bresp} pairs in push order and owns the
// bvalid/bready handshake, with a registered head copy and per-ID pending tracking.
module axi_bresp_queue #(
    parameter int  ID_W  = 2,
    parameter int  DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [ID_W-1:0]      push_id,
    input  logic [1:0]           push_resp,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [ID_W-1:0]      bid,
    output logic [1:0]           bresp,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic [2**ID_W-1:0]   id_pending,
    output logic                 overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int NID = 2**ID_W;
    localparam int EW  = ID_W + 2;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    ptr_diff_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             bvalid_q, bvalid_d;
    logic [ID_W-1:0]  bid_q, bid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] id_cnt_q [NID];
    logic [CNT_W-1:0] id_cnt_d [NID];
    logic [NID-1:0]   id_pending_q, id_pending_d;
    logic [EW-1:0]    head_entry_s;
    logic             push_s;
    logic             pop_s;

    // Next-state for pointers, occupancy, head copy, per-ID counters and sticky overflow.
    always_comb begin
        push_s       = push_valid && !full_q;
        pop_s        = bvalid_q && bready;
        wr_ptr_d     = wr_ptr_q + (push_s ? PW'(1) : PW'(0));
        rd_ptr_d     = rd_ptr_q + (pop_s ? PW'(1) : PW'(0));
        ptr_diff_s   = wr_ptr_d - rd_ptr_d;
        count_d      = CNT_W'(ptr_diff_s);
        empty_d      = (wr_ptr_d == rd_ptr_d);
        full_d       = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        bvalid_d     = !empty_d;
        overflow_d   = overflow_q || (push_valid && full_q);
        head_entry_s = mem_q[rd_ptr_d[AW-1:0]];

        // The new head is the entry being written this cycle when the queue drains to it.
        if (empty_d) begin
            bid_d   = bid_q;
            bresp_d = bresp_q;
        end else if (rd_ptr_d == wr_ptr_q) begin
            bid_d   = push_id;
            bresp_d = push_resp;
        end else begin
            bid_d   = head_entry_s[EW-1:2];
            bresp_d = head_entry_s[1:0];
        end

        for (int i = 0; i < NID; i++) begin
            id_cnt_d[i] = id_cnt_q[i];
            if (push_s && (push_id == ID_W'(i))) begin
                id_cnt_d[i] = id_cnt_d[i] + CNT_W'(1);
            end else begin
                id_cnt_d[i] = id_cnt_d[i];
            end
            if (pop_s && (bid_q == ID_W'(i))) begin
                id_cnt_d[i] = id_cnt_d[i] - CNT_W'(1);
            end else begin
                id_cnt_d[i] = id_cnt_d[i];
            end
            id_pending_d[i] = (id_cnt_d[i] != CNT_W'(0));
        end
    end

    // Control and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= PW'(0);
            rd_ptr_q     <= PW'(0);
            count_q      <= CNT_W'(0);
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            bvalid_q     <= 1'b0;
            bid_q        <= ID_W'(0);
            bresp_q      <= 2'b00;
            overflow_q   <= 1'b0;
            id_pending_q <= NID'(0);
            for (int i = 0; i < NID; i++) begin
                id_cnt_q[i] <= CNT_W'(0);
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            bvalid_q     <= bvalid_d;
            bid_q        <= bid_d;
            bresp_q      <= bresp_d;
            overflow_q   <= overflow_d;
            id_pending_q <= id_pending_d;
            for (int i = 0; i < NID; i++) begin
                id_cnt_q[i] <= id_cnt_d[i];
            end
        end
    end

    // Response storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {push_id, push_resp};
        end
    end

    assign push_ready = !full_q;
    assign bvalid     = bvalid_q;
    assign bid        = bid_q;
    assign bresp      = bresp_q;
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign id_pending = id_pending_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_axi_bresp_queue.sv
// Self-checking bench for axi_bresp_queue: a reference queue of {id,resp} is pushed on
// accepted stimulus and popped/compared on each B-channel handshake.
module tb_axi_bresp_queue;

    localparam int ID_W  = 2;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int NID   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid;
    logic              push_ready;
    logic [ID_W-1:0]   push_id;
    logic [1:0]        push_resp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [NID-1:0]    id_pending;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    logic [ID_W+1:0] sb [$];
    logic            m_ovf;
    logic            hold_prev;
    logic [ID_W+1:0] prev_out;

    axi_bresp_queue #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_id(push_id), .push_resp(push_resp),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .count(count), .full(full), .empty(empty),
        .id_pending(id_pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; scoreboard compare at negedge, then model update.
    task automatic cycle(input logic pv, input logic [ID_W-1:0] id, input logic [1:0] rs,
                         input logic br);
        logic [ID_W+1:0] exp_e;
        logic [ID_W+1:0] ent;
        logic [NID-1:0]  exp_pend;
        int              sz;
        push_valid = pv;
        push_id    = id;
        push_resp  = rs;
        bready     = br;
        @(negedge clk);
        sz       = sb.size();
        exp_pend = '0;
        for (int k = 0; k < sz; k++) begin
            ent = sb[k];
            exp_pend[ent[ID_W+1:2]] = 1'b1;
        end
        checks++;
        if (bvalid !== (sz != 0)) begin
            errors++; $display("FAIL bvalid: got %b want %b", bvalid, (sz != 0));
        end
        checks++;
        if (count !== CNT_W'(sz)) begin
            errors++; $display("FAIL count: got %0d want %0d", count, sz);
        end
        checks++;
        if (id_pending !== exp_pend) begin
            errors++; $display("FAIL id_pending: got %b want %b", id_pending, exp_pend);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++; $display("FAIL overflow: got %b want %b", overflow, m_ovf);
        end
        checks++;
        if (push_ready !== (sz != DEPTH)) begin
            errors++; $display("FAIL push_ready: got %b want %b", push_ready, (sz != DEPTH));
        end
        if (hold_prev) begin
            checks++;
            if ({bvalid, bid, bresp} !== {1'b1, prev_out}) begin
                errors++;
                $display("FAIL axi_stable: got v=%b id=%0d resp=%b want v=1 id=%0d resp=%b",
                         bvalid, bid, bresp, prev_out[ID_W+1:2], prev_out[1:0]);
            end
        end
        hold_prev = bvalid && !br;
        prev_out  = {bid, bresp};
        if (sz != 0 && br) begin
            exp_e = sb.pop_front();
            checks++;
            if ({bid, bresp} !== exp_e) begin
                errors++;
                $display("FAIL b_order: got id=%0d resp=%b want id=%0d resp=%b",
                         bid, bresp, exp_e[ID_W+1:2], exp_e[1:0]);
            end
        end
        if (pv) begin
            if (sz < DEPTH) sb.push_back({id, rs});
            else            m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        bready     = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_ovf     = 1'b0;
        hold_prev = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bvalid, count, full, empty, id_pending, overflow, bid, bresp} !==
            {1'b0, 4'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: got v=%b cnt=%0d f=%b e=%b pend=%b ovf=%b id=%0d resp=%b",
                     bvalid, count, full, empty, id_pending, overflow, bid, bresp);
        end
    endtask

    task automatic test_single();
        do_reset();
        cycle(1'b1, 2'd2, 2'b00, 1'b1);
        checks++;
        if ({bvalid, bid, bresp} !== {1'b1, 2'd2, 2'b00}) begin
            errors++; $display("FAIL single_latency: got v=%b id=%0d resp=%b want v=1 id=2 resp=00",
                               bvalid, bid, bresp);
        end
        cycle(1'b0, 2'd0, 2'b00, 1'b1);
        checks++;
        if ({empty, id_pending} !== {1'b1, 4'b0000}) begin
            errors++; $display("FAIL single_drain: got e=%b pend=%b want e=1 pend=0000",
                               empty, id_pending);
        end
    endtask

    task automatic test_fill();
        logic [1:0] rs;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            rs = (i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b10 : 2'b11);
            cycle(1'b1, ID_W'(i % NID), rs, 1'b0);
        end
        checks++;
        if ({full, push_ready, count, id_pending, bid} !== {1'b1, 1'b0, 4'd8, 4'b1111, 2'd0}) begin
            errors++; $display("FAIL fill: got f=%b rdy=%b cnt=%0d pend=%b id=%0d",
                               full, push_ready, count, id_pending, bid);
        end
        repeat (20) cycle(1'b0, 2'd0, 2'b00, 1'b0);
        cycle(1'b1, 2'd1, 2'b01, 1'b0);
        checks++;
        if ({overflow, count, bid} !== {1'b1, 4'd8, 2'd0}) begin
            errors++; $display("FAIL overflow_push: got ovf=%b cnt=%0d id=%0d want ovf=1 cnt=8 id=0",
                               overflow, count, bid);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bvalid !== 1'b1) begin
                errors++; $display("FAIL drain_bubble: cycle %0d got bvalid=%b want 1", i, bvalid);
            end
            cycle(1'b0, 2'd0, 2'b00, 1'b1);
        end
        checks++;
        if ({empty, bvalid} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL drain_end: got e=%b v=%b want e=1 v=0", empty, bvalid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, ID_W'(i), 2'b00, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, ID_W'((i + 3) % NID), 2'b10, 1'b1);
            checks++;
            if (count !== 4'd3) begin
                errors++; $display("FAIL steady_count: cycle %0d got %0d want 3", i, count);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, ID_W'(i % NID), 2'b11, 1'b0);
        checks++;
        if ({bvalid, count} !== {1'b1, 4'd5}) begin
            errors++; $display("FAIL premid: got v=%b cnt=%0d want v=1 cnt=5", bvalid, count);
        end
        do_reset();
        checks++;
        if ({bvalid, count, id_pending, overflow, empty} !== {1'b0, 4'd0, 4'b0000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_mid: got v=%b cnt=%0d pend=%b ovf=%b e=%b",
                               bvalid, count, id_pending, overflow, empty);
        end
        cycle(1'b0, 2'd0, 2'b00, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            r = $urandom;
            cycle(r[0], r[ID_W+1:2], r[ID_W+3:ID_W+2], r[8]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_id    = '0;
        push_resp  = 2'b00;
        bready     = 1'b0;
        m_ovf      = 1'b0;
        hold_prev  = 1'b0;
        prev_out   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
